// File: rtl/dht11_pkg.sv
// Shared DHT11 definitions: FSM encoding, frame size and the default protocol timing
// used by both the sensor model and the host controller.
package dht11_pkg;

  localparam int unsigned FRAME_BITS     = 40;
  localparam int unsigned CLK_PER_US_DEF = 50;
  localparam int unsigned T_START_MIN_US = 18000;
  localparam int unsigned T_RESP_DLY_US  = 30;
  localparam int unsigned T_ACK_LOW_US   = 80;
  localparam int unsigned T_ACK_HIGH_US  = 80;
  localparam int unsigned T_BIT_LOW_US   = 50;
  localparam int unsigned T_BIT0_HIGH_US = 28;
  localparam int unsigned T_BIT1_HIGH_US = 70;

  typedef enum logic [6:0] {
    ST_IDLE     = 7'b0000001,
    ST_HOST_LOW = 7'b0000010,
    ST_RESP_DLY = 7'b0000100,
    ST_ACK_LOW  = 7'b0001000,
    ST_ACK_HIGH = 7'b0010000,
    ST_BIT_LOW  = 7'b0100000,
    ST_BIT_HIGH = 7'b1000000
  } dht11_state_e;

  // Checksum byte; err_inj flips bit0 so a host sees a deliberately corrupted frame.
  function automatic logic [7:0] dht11_checksum(input logic [7:0] hi, input logic [7:0] hd,
                                                input logic [7:0] ti, input logic [7:0] td,
                                                input logic       err);
    logic [7:0] sum;
    sum = hi + hd + ti + td;
    return sum ^ {7'b0, err};
  endfunction

  // True on the microsecond tick that completes a phase of len_us microseconds.
  function automatic logic phase_end(input logic tick, input logic [15:0] cnt,
                                     input int unsigned len_us);
    return tick && (cnt == 16'(len_us - 1));
  endfunction

endpackage

// File: rtl/dht11_us_tick.sv
// Microsecond prescaler: counts 0..CLK_PER_US-1 and flags the terminal count.
// A synchronous clear restarts the microsecond so every phase starts aligned.
module dht11_us_tick #(
  parameter int unsigned CLK_PER_US = 50
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic clr,
  output logic us_tick
);

  localparam int unsigned PW = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
  localparam logic [PW-1:0] TERM = PW'(CLK_PER_US - 1);

  logic [PW-1:0] cnt_q;

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n || clr) begin
      cnt_q <= '0;
    end else if (cnt_q == TERM) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + PW'(1);
    end
  end

  assign us_tick = (cnt_q == TERM);

endmodule

// File: rtl/dht11_sensor_model.sv
// DHT11 responder: detects a host start pulse on the open-drain line, then sends the
// acknowledge and a 40-bit humidity/temperature/checksum frame MSB first.
module dht11_sensor_model
  import dht11_pkg::*;
#(
  parameter int unsigned CLK_PER_US     = CLK_PER_US_DEF,
  parameter int unsigned T_START_MIN_US = dht11_pkg::T_START_MIN_US,
  parameter int unsigned T_RESP_DLY_US  = dht11_pkg::T_RESP_DLY_US,
  parameter int unsigned T_ACK_LOW_US   = dht11_pkg::T_ACK_LOW_US,
  parameter int unsigned T_ACK_HIGH_US  = dht11_pkg::T_ACK_HIGH_US,
  parameter int unsigned T_BIT_LOW_US   = dht11_pkg::T_BIT_LOW_US,
  parameter int unsigned T_BIT0_HIGH_US = dht11_pkg::T_BIT0_HIGH_US,
  parameter int unsigned T_BIT1_HIGH_US = dht11_pkg::T_BIT1_HIGH_US
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic [7:0] hum_int,
  input  logic [7:0] hum_dec,
  input  logic [7:0] tmp_int,
  input  logic [7:0] tmp_dec,
  input  logic       err_inj,
  inout  wire        data_inout,
  output logic       busy,
  output logic       frame_done
);

  dht11_state_e state_q, state_d;
  logic         sync_ff1, line_s;
  logic         us_tick, state_chg;
  logic [15:0]  us_cnt;
  logic [5:0]   bit_cnt;
  logic [FRAME_BITS-1:0] shift_q;
  logic         drive_low;
  logic         snap, shift_en, done_d;
  logic [7:0]   chk;

  // Line synchronizer idles high to match the pulled-up bus.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      sync_ff1 <= 1'b1;
      line_s   <= 1'b1;
    end else begin
      sync_ff1 <= data_inout;
      line_s   <= sync_ff1;
    end
  end

  assign state_chg = (state_d != state_q);

  dht11_us_tick #(.CLK_PER_US(CLK_PER_US)) u_us_tick (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .clr       (state_chg),
    .us_tick   (us_tick)
  );

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n || state_chg) begin
      us_cnt <= '0;
    end else if (us_tick && (us_cnt != 16'hFFFF)) begin
      us_cnt <= us_cnt + 16'd1;
    end
  end

  assign chk = dht11_checksum(hum_int, hum_dec, tmp_int, tmp_dec, err_inj);

  always_comb begin
    state_d  = state_q;
    snap     = 1'b0;
    shift_en = 1'b0;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!line_s) state_d = ST_HOST_LOW;
      end
      ST_HOST_LOW: begin
        if (line_s) begin
          if (us_cnt >= 16'(T_START_MIN_US)) begin
            state_d = ST_RESP_DLY;
            snap    = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_RESP_DLY: begin
        if (phase_end(us_tick, us_cnt, T_RESP_DLY_US)) state_d = ST_ACK_LOW;
      end
      ST_ACK_LOW: begin
        if (phase_end(us_tick, us_cnt, T_ACK_LOW_US)) state_d = ST_ACK_HIGH;
      end
      ST_ACK_HIGH: begin
        if (phase_end(us_tick, us_cnt, T_ACK_HIGH_US)) state_d = ST_BIT_LOW;
      end
      ST_BIT_LOW: begin
        // The low after the last bit doubles as the end-of-frame marker.
        if (phase_end(us_tick, us_cnt, T_BIT_LOW_US)) begin
          if (bit_cnt == 6'(FRAME_BITS)) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_BIT_HIGH;
          end
        end
      end
      ST_BIT_HIGH: begin
        if (phase_end(us_tick, us_cnt,
                      shift_q[FRAME_BITS-1] ? T_BIT1_HIGH_US : T_BIT0_HIGH_US)) begin
          state_d  = ST_BIT_LOW;
          shift_en = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered from state_d so they change on the same edge as the state.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q    <= ST_IDLE;
      drive_low  <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      bit_cnt    <= '0;
      shift_q    <= '0;
    end else begin
      state_q    <= state_d;
      drive_low  <= (state_d == ST_ACK_LOW) || (state_d == ST_BIT_LOW);
      busy       <= !((state_d == ST_IDLE) || (state_d == ST_HOST_LOW));
      frame_done <= done_d;
      if (snap) begin
        shift_q <= {hum_int, hum_dec, tmp_int, tmp_dec, chk};
        bit_cnt <= '0;
      end else if (shift_en) begin
        shift_q <= {shift_q[FRAME_BITS-2:0], 1'b0};
        bit_cnt <= bit_cnt + 6'd1;
      end
    end
  end

  assign data_inout = drive_low ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_dht11_sensor_model.sv
// Bench for dht11_sensor_model: a host driver issues start pulses, a bus monitor
// decodes the sensor waveform and checks it against frames queued by the stimulus.
module tb_dht11_sensor_model;

  localparam int C  = 2;    // sys_clk cycles per us (scaled down for run time)
  localparam int TS = 200;  // minimum start length in us (scaled down)

  logic       sys_clk;
  logic       sys_rst_n;
  logic [7:0] hum_int, hum_dec, tmp_int, tmp_dec;
  logic       err_inj;
  logic       host_low;
  logic       busy, frame_done;
  wire        data_line;

  pullup (data_line);
  assign data_line = host_low ? 1'b0 : 1'bz;

  dht11_sensor_model #(
    .CLK_PER_US     (C),
    .T_START_MIN_US (TS)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .hum_int    (hum_int),
    .hum_dec    (hum_dec),
    .tmp_int    (tmp_int),
    .tmp_dec    (tmp_dec),
    .err_inj    (err_inj),
    .data_inout (data_line),
    .busy       (busy),
    .frame_done (frame_done)
  );

  // ---------------- clock / reset ----------------
  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // ---------------- scoreboard ----------------
  logic [39:0] exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic        expect_abort = 1'b0;

  task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- bus monitor ----------------
  logic        mon_active = 1'b0;
  logic        prev;
  int          run;
  int          mon_k = 0;
  int          bad_seg;
  logic [39:0] bits;
  logic [39:0] exp_frame;

  task automatic close_seg();
    int j;
    if (mon_k == 0) begin
      check_eq("resp_dly_len", 64'(run), 64'(30 * C));
    end else if (mon_k == 1) begin
      check_eq("ack_low_len", 64'(run), 64'(80 * C));
    end else if (mon_k == 2) begin
      check_eq("ack_high_len", 64'(run), 64'(80 * C));
    end else begin
      j = mon_k - 3;
      if (j % 2 == 0) begin
        if (prev !== 1'b0 || run != 50 * C) bad_seg++;
      end else if (prev !== 1'b1) begin
        bad_seg++;
      end else if (run == 70 * C) begin
        bits = {bits[38:0], 1'b1};
      end else if (run == 28 * C) begin
        bits = {bits[38:0], 1'b0};
      end else begin
        bad_seg++;
      end
    end
    mon_k++;
  endtask

  always @(negedge sys_clk) begin
    if (mon_active) begin
      if (!busy) begin
        if (frame_done) begin
          check_eq("eof_low_len", 64'(run), 64'(50 * C));
          check_eq("segment_count", 64'(mon_k), 64'(83));
          check_eq("segment_errors", 64'(bad_seg), 64'(0));
          if (exp_q.size() == 0) begin
            check_eq("frame_unexpected", 64'(1), 64'(0));
          end else begin
            exp_frame = exp_q.pop_front();
            check_eq("frame_bits", 64'(bits), 64'(exp_frame));
          end
        end else begin
          check_eq("abort_expected", 64'(expect_abort), 64'(1));
          if (exp_q.size() != 0) exp_frame = exp_q.pop_front();
        end
        mon_active = 1'b0;
        mon_k      = 0;
      end else if (data_line === prev) begin
        run++;
      end else begin
        close_seg();
        prev = data_line;
        run  = 1;
      end
    end else if (busy) begin
      mon_active = 1'b1;
      prev       = data_line;
      run        = 1;
      mon_k      = 0;
      bad_seg    = 0;
      bits       = '0;
      check_eq("start_expected", 64'(exp_q.size() != 0), 64'(1));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_inputs(input logic [7:0] hi, input logic [7:0] hd,
                            input logic [7:0] ti, input logic [7:0] td, input logic err);
    hum_int = hi; hum_dec = hd; tmp_int = ti; tmp_dec = td; err_inj = err;
  endtask

  task automatic host_start(input int len_us);
    @(negedge sys_clk);
    host_low = 1'b1;
    repeat (len_us * C) @(negedge sys_clk);
    host_low = 1'b0;
  endtask

  task automatic wait_frame(input string name);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge sys_clk);
      if (frame_done) begin
        seen = 1'b1;
        break;
      end
    end
    check_eq(name, 64'(seen), 64'(1));
    repeat (20) @(negedge sys_clk);
  endtask

  task automatic wait_segment(input string name, input int target);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge sys_clk);
      if (mon_k == target) begin
        seen = 1'b1;
        break;
      end
    end
    check_eq(name, 64'(seen), 64'(1));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic busy_seen, low_seen;
    host_low  = 1'b0;
    sys_rst_n = 1'b0;
    set_inputs(8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    repeat (5) @(posedge sys_clk);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    @(posedge sys_clk); #1;
    check_eq("reset_busy", 64'(busy), 64'(0));
    check_eq("reset_frame_done", 64'(frame_done), 64'(0));
    check_eq("reset_line", 64'(data_line), 64'(1));
    repeat (10) @(negedge sys_clk);

    // Normal frame: 55.0 %RH, 25.5 C
    set_inputs(8'd55, 8'd0, 8'd25, 8'd5, 1'b0);
    exp_q.push_back(40'h37_00_19_05_55);
    host_start(TS + 10);
    wait_frame("case1_done");

    // Short start pulse must be ignored
    host_start(50);
    busy_seen = 1'b0;
    low_seen  = 1'b0;
    repeat (2000) begin
      @(negedge sys_clk);
      if (busy) busy_seen = 1'b1;
      if (data_line !== 1'b1) low_seen = 1'b1;
    end
    check_eq("short_busy", 64'(busy_seen), 64'(0));
    check_eq("short_line_driven", 64'(low_seen), 64'(0));

    // Error injection flips checksum bit0
    set_inputs(8'd55, 8'd0, 8'd25, 8'd5, 1'b1);
    exp_q.push_back(40'h37_00_19_05_54);
    host_start(TS + 10);
    wait_frame("case3_done");

    // Negative temperature: -12.3 C encoded as 12 / 0x83
    set_inputs(8'd40, 8'd0, 8'd12, 8'h83, 1'b0);
    exp_q.push_back(40'h28_00_0C_83_B7);
    host_start(TS + 10);
    wait_frame("case4_done");

    // Reset during the low phase of bit 17, then a clean frame
    set_inputs(8'd55, 8'd0, 8'd25, 8'd5, 1'b0);
    exp_q.push_back(40'h37_00_19_05_55);
    expect_abort = 1'b1;
    host_start(TS + 10);
    wait_segment("case5_reach_bit17", 3 + 2 * 17);
    repeat (10) @(negedge sys_clk);
    check_eq("case5_prereset_low", 64'(data_line), 64'(0));
    sys_rst_n = 1'b0;
    @(posedge sys_clk); #1;
    check_eq("case5_reset_line", 64'(data_line), 64'(1));
    check_eq("case5_reset_busy", 64'(busy), 64'(0));
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (10) @(negedge sys_clk);
    expect_abort = 1'b0;
    set_inputs(8'h3C, 8'h01, 8'h14, 8'h02, 1'b0);
    exp_q.push_back(40'h3C_01_14_02_53);
    host_start(TS + 10);
    wait_frame("case5_done");

    // Long start, inputs changed mid-frame must not leak into the frame
    set_inputs(8'h50, 8'h00, 8'h1E, 8'h00, 1'b0);
    exp_q.push_back(40'h50_00_1E_00_6E);
    host_start(TS * 3);
    wait_segment("case6_reach_bit3_high", 3 + 2 * 3 + 1);
    set_inputs(8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b1);
    wait_frame("case6_done");

    check_eq("queue_empty", 64'(exp_q.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
